// File: rtl/odnet_pkg.sv
// Shared types and helpers for the open-drain line receiver (odnet_rx).
package odnet_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } state_e;

    localparam int                GLITCH_CNT_W   = 8;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'd255;

    // Settle counter must hold the larger of the two qualification targets.
    function automatic int cnt_width(input int rise_cycles, input int fall_cycles);
        int m;
        m = (rise_cycles > fall_cycles) ? rise_cycles : fall_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/odnet_sync.sv
// N-stage synchronizer whose flops all reset to a configurable value.
module odnet_sync #(
    parameter int   N           = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stage_q;
    logic [N-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {N{RESET_VALUE}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/odnet_rx.sv
// Open-drain net receiver: synchronize, qualify with asymmetric settle counts, emit strobes.
// Optional saturating glitch counter enabled by ODNET_GLITCH_COUNT_EN.
module odnet_rx
    import odnet_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   RISE_CYCLES = 4,
    parameter int   FALL_CYCLES = 1,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall,
`ifdef ODNET_GLITCH_COUNT_EN
    output logic glitch,
    output logic [GLITCH_CNT_W-1:0] glitch_count
`else
    output logic glitch
`endif
);

    localparam int CNT_W = cnt_width(RISE_CYCLES, FALL_CYCLES);
    localparam logic [CNT_W-1:0] RISE_TGT = CNT_W'(RISE_CYCLES);
    localparam logic [CNT_W-1:0] FALL_TGT = CNT_W'(FALL_CYCLES);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;

    odnet_sync #(
        .N           (SYNC_STAGES),
        .RESET_VALUE (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (line),
        .q   (s)
    );

    assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            LOW: begin
                if (s) begin
                    if (RISE_CYCLES == 1) begin
                        state_d = HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = RISE;
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            RISE: begin
                if (s) begin
                    if (cnt_inc == RISE_TGT) begin
                        state_d = HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d  = LOW;
                    glitch_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (FALL_CYCLES == 1) begin
                        state_d = LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = FALL;
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            FALL: begin
                if (!s) begin
                    if (cnt_inc == FALL_TGT) begin
                        state_d = LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d  = HIGH;
                    glitch_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = RESET_LEVEL ? HIGH : LOW;
                level_d = RESET_LEVEL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_LEVEL ? HIGH : LOW;
            cnt_q    <= '0;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign level  = level_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign glitch = glitch_q;

`ifdef ODNET_GLITCH_COUNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

    // Counts alongside the strobe it accompanies, holding at full scale.
    always_comb begin
        if (glitch_d && (glitch_cnt_q != GLITCH_CNT_MAX)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end else begin
            glitch_cnt_d = glitch_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_count = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_odnet_rx.sv
// Directed self-checking bench for odnet_rx at default parameters.
module tb_odnet_rx;

    logic       clk;
    logic       rst;
    logic       line;
    logic       level;
    logic       rise;
    logic       fall;
    logic       glitch;
`ifdef ODNET_GLITCH_COUNT_EN
    logic [7:0] glitch_count;
`endif

    int errors;
    int checks;
    int rise_ev;
    int fall_ev;
    int glitch_ev;
    int excl_viol;
    int snap_rise;
    int snap_fall;
    int snap_glitch;
    int level_rose;

    odnet_rx dut (
        .clk          (clk),
        .rst          (rst),
        .line         (line),
        .level        (level),
        .rise         (rise),
        .fall         (fall),
`ifdef ODNET_GLITCH_COUNT_EN
        .glitch       (glitch),
        .glitch_count (glitch_count)
`else
        .glitch       (glitch)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe tallies, sampled mid-cycle so they are settled by the next check.
    always @(negedge clk) begin
        if (rise)   rise_ev   <= rise_ev + 1;
        if (fall)   fall_ev   <= fall_ev + 1;
        if (glitch) glitch_ev <= glitch_ev + 1;
        if ((rise && fall) || (glitch && (rise || fall))) excl_viol <= excl_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rise_ev = 0; fall_ev = 0; glitch_ev = 0; excl_viol = 0;
        level_rose = 0;
        rst  = 1'b1;
        line = 1'b1;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("reset_level", 32'(level), 32'd1);
        check("reset_rise", 32'(rise), 32'd0);
        check("reset_fall", 32'(fall), 32'd0);
        check("reset_glitch", 32'(glitch), 32'd0);
`ifdef ODNET_GLITCH_COUNT_EN
        check("reset_gcount", 32'(glitch_count), 32'd0);
`endif
        tick(20);
        check("idle_level", 32'(level), 32'd1);
        check("idle_strobes", 32'(rise_ev + fall_ev + glitch_ev), 32'd0);

        // Clean fall: 2 sync + 1 settle edges
        line = 1'b0;
        tick(2);
        check("fall_lat2_level", 32'(level), 32'd1);
        check("fall_lat2_strobe", 32'(fall), 32'd0);
        tick(1);
        check("fall_lat3_level", 32'(level), 32'd0);
        check("fall_lat3_strobe", 32'(fall), 32'd1);
        check("fall_lat3_glitch", 32'(glitch), 32'd0);
        tick(1);
        check("fall_one_cycle", 32'(fall), 32'd0);
        tick(4);

        // Clean rise: 2 sync + 4 settle edges
        line = 1'b1;
        tick(5);
        check("rise_lat5_level", 32'(level), 32'd0);
        check("rise_lat5_strobe", 32'(rise), 32'd0);
        tick(1);
        check("rise_lat6_level", 32'(level), 32'd1);
        check("rise_lat6_strobe", 32'(rise), 32'd1);
        tick(1);
        check("rise_one_cycle", 32'(rise), 32'd0);
        check("rise_level_hold", 32'(level), 32'd1);
        check("glitch_none_yet", 32'(glitch_ev), 32'd0);

        // Return low, then a two-cycle high blip
        line = 1'b0;
        tick(6);
        check("low_again", 32'(level), 32'd0);
        snap_rise = rise_ev;
        line = 1'b1;
        tick(2);
        line = 1'b0;
        tick(6);
        check("blip_glitch_cnt", 32'(glitch_ev), 32'd1);
        check("blip_level", 32'(level), 32'd0);
        check("blip_no_rise", 32'(rise_ev - snap_rise), 32'd0);
`ifdef ODNET_GLITCH_COUNT_EN
        check("blip_gcount", 32'(glitch_count), 32'd1);
`endif

        // 300 blips: each abandoned, level never rises
        snap_glitch = glitch_ev;
        snap_rise   = rise_ev;
        snap_fall   = fall_ev;
        for (int p = 0; p < 300; p++) begin
            line = 1'b1;
            tick(2);
            if (level !== 1'b0) level_rose = level_rose + 1;
            line = 1'b0;
            tick(2);
            if (level !== 1'b0) level_rose = level_rose + 1;
        end
        tick(4);
        check("burst_glitches", 32'(glitch_ev - snap_glitch), 32'd300);
        check("burst_level_stuck", 32'(level_rose), 32'd0);
        check("burst_no_edges", 32'((rise_ev - snap_rise) + (fall_ev - snap_fall)), 32'd0);
`ifdef ODNET_GLITCH_COUNT_EN
        check("burst_gcount_sat", 32'(glitch_count), 32'd255);
`endif

        // Reset during RISE with cnt=3 discards the candidate
        snap_rise = rise_ev;
        line = 1'b1;
        tick(5);
        check("pre_rst_level", 32'(level), 32'd0);
        rst = 1'b1;
        tick(1);
        check("mid_rst_level", 32'(level), 32'd1);
        check("mid_rst_rise", 32'(rise), 32'd0);
        rst = 1'b0;
        tick(10);
        check("post_rst_no_rise", 32'(rise_ev - snap_rise), 32'd0);
        check("post_rst_level", 32'(level), 32'd1);
`ifdef ODNET_GLITCH_COUNT_EN
        check("post_rst_gcount", 32'(glitch_count), 32'd0);
`endif
        check("strobe_exclusive", 32'(excl_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/odnet_rx.md
Name: odnet_rx

Overview:
- Receiving end of an open-drain net: a pulled-up line driven low by one or more pull-down FETs, with slow RC rise and fast fall.
- Synchronizes the raw pin, then qualifies it with asymmetric settle counts.
- Produces a clean level, single-cycle edge strobes, and a glitch strobe.
- Sits between any discrete open-drain bus line and synchronous logic in the q2 hardware model and FPGA bring-up.

Parameters:
- SYNC_STAGES, 2, synchronizer flops ahead of the qualifier (min 2).
- RISE_CYCLES, 4, consecutive synchronized 1 samples required to accept a rising edge (min 1, max 255).
- FALL_CYCLES, 1, consecutive synchronized 0 samples required to accept a falling edge (min 1, max 255).
- RESET_LEVEL, 1, level assumed at reset; pulled-up idle is 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- line  input  1  raw open-drain net, asynchronous to clk
- level  output  1  qualified line level
- rise  output  1  one-cycle strobe when level goes 0->1
- fall  output  1  one-cycle strobe when level goes 1->0
- glitch  output  1  one-cycle strobe when a candidate edge is abandoned before qualifying
- glitch_count  output  8  saturating glitch counter; present only with ODNET_GLITCH_COUNT_EN

Behaviour:
- Reset (sampled on a rising clk while rst=1):
  - all synchronizer flops = RESET_LEVEL; state = HIGH if RESET_LEVEL else LOW
  - level = RESET_LEVEL; settle counter = 0; rise = fall = glitch = 0; glitch_count = 0
  - rst dominates every other event in the same cycle; a reset mid-qualification discards the candidate edge with no strobe.
- Synchronizer: s = line delayed SYNC_STAGES clk edges. No other logic uses line directly.
- State machine, evaluated on s each edge:
  - LOW:
    - s=1 and RISE_CYCLES=1 -> HIGH directly; level=1, rise=1.
    - s=1 and RISE_CYCLES>1 -> RISE, cnt=1.
  - RISE:
    - s=1: cnt+1. When cnt+1 == RISE_CYCLES -> HIGH; level=1, rise=1.
    - s=0: -> LOW; glitch=1; cnt=0.
  - HIGH and FALL: mirror of LOW and RISE, using FALL_CYCLES and the fall strobe.
- Latency: a clean pin edge reaches level after SYNC_STAGES + RISE_CYCLES clk edges for a rise, SYNC_STAGES + FALL_CYCLES for a fall.
- Strobes:
  - rise/fall are asserted in the same cycle level changes; they are registered and never both high.
  - glitch is mutually exclusive with rise/fall.
  - level holds through RISE/FALL; only a qualified transition changes it.
- Counter:
  - width = clog2(max(RISE_CYCLES, FALL_CYCLES) + 1).
  - cnt never exceeds the target and is cleared on every state entry to LOW/HIGH.
- Sustained toggling faster than qualification never changes level and produces one glitch per abandoned candidate.

Optional Feature:
- Macro: ODNET_GLITCH_COUNT_EN.
- When defined:
  - glitch_count port exists.
  - It increments on each glitch strobe and saturates at 255; it does not wrap.
  - It is cleared only by rst.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package odnet_pkg:
  - state enum {LOW, RISE, HIGH, FALL}, 2 bits
  - GLITCH_CNT_W = 8 and the saturate value
  - a function returning the counter width from RISE_CYCLES/FALL_CYCLES
- Sub-module odnet_sync:
  - parameterized N-stage reset-to-value synchronizer, with RESET_LEVEL as its reset value.
  - odnet_rx instantiates it once.

Test Plan:
- Reset with RESET_LEVEL=1, line=1 -> level=1; rise, fall and glitch=0; glitch_count=0; no strobes for 20 cycles.
- Defaults, line 1->0 at edge 10 -> level falls and fall pulses at edge 13 (2+1); no glitch.
- Defaults, line 0->1 held -> level rises and rise pulses exactly 6 edges later (2+4), for one cycle.
- Defaults, level=0, line high for 2 cycles then low -> glitch pulses once; level stays 0; glitch_count=1.
- 300 two-cycle high pulses at RISE_CYCLES=4 -> 300 glitch strobes; level never rises; glitch_count saturates at 255.
- rst asserted while state=RISE with cnt=3 -> no rise strobe; level=RESET_LEVEL the next cycle; counter cleared.
